// File: rtl/lfsr_pattern_gen.sv
// lfsr_pattern_gen: seeded maximal-length Fibonacci LFSR pattern source with a sticky period-complete flag
module lfsr_pattern_gen #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] seed,
    output logic [NUM_BITS:1]   out,
    output logic                LFSR_Done
);
    // bit k-1 set means tap k of out[NUM_BITS:1] feeds the XOR
    function automatic logic [31:0] tap_mask(input int n);
        case (n)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    localparam logic [31:0] TAP_MASK = tap_mask(NUM_BITS);

    if (NUM_BITS < 2 || NUM_BITS > 32) begin : g_bad_width
        $error("lfsr_pattern_gen: NUM_BITS must be in 2..32");
    end

    logic [NUM_BITS:1] taps;
    logic [NUM_BITS:1] load;
    logic [NUM_BITS:1] nxt;
    logic [NUM_BITS:1] seed_q;

    // an all-zero seed would lock the register, so 1 is substituted
    always_comb begin
        taps = TAP_MASK[NUM_BITS-1:0];
        load = (seed == '0) ? {{(NUM_BITS-1){1'b0}}, 1'b1} : seed;
        nxt  = {out[NUM_BITS-1:1], ^(out & taps)};
    end

    // reset loads the seed; otherwise step until the seed comes round again, then hold
    always_ff @(posedge clk) begin
        if (n_rst) begin
            out       <= load;
            seed_q    <= load;
            LFSR_Done <= 1'b0;
        end else if (!LFSR_Done) begin
            out       <= nxt;
            LFSR_Done <= (nxt == seed_q);
        end
    end
endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// tb_lfsr_pattern_gen: randomized self-checking bench against a tap-list reference model
module tb_lfsr_pattern_gen;
    logic clk = 0;
    always #5 clk = ~clk;

    logic        rst4, rst8, rst16;
    logic [3:0]  seed4;
    logic [7:0]  seed8;
    logic [15:0] seed16;
    logic [4:1]  out4;
    logic [8:1]  out8;
    logic [16:1] out16;
    logic        done4, done8, done16;

    lfsr_pattern_gen #(.NUM_BITS(4)) u4 (
        .clk(clk), .n_rst(rst4), .seed(seed4), .out(out4), .LFSR_Done(done4)
    );
    lfsr_pattern_gen #(.NUM_BITS(8)) u8 (
        .clk(clk), .n_rst(rst8), .seed(seed8), .out(out8), .LFSR_Done(done8)
    );
    lfsr_pattern_gen #(.NUM_BITS(16)) u16 (
        .clk(clk), .n_rst(rst16), .seed(seed16), .out(out16), .LFSR_Done(done16)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // next state from the published tap list: shift up, XOR of tapped bits enters bit 1
    function automatic logic [31:0] ref_next(input int n, input logic [31:0] s);
        int t[$];
        logic fb;
        case (n)
            4:       t = '{4, 3};
            8:       t = '{8, 6, 5, 4};
            default: t = '{16, 15, 13, 4};
        endcase
        fb = 1'b0;
        foreach (t[i]) fb ^= s[t[i]-1];
        return ((s << 1) | {31'd0, fb}) & ((32'd1 << n) - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] seq [15] = '{4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001,
                             4'b0011};

    bit vis8 [256];
    bit vis16 [65536];

    initial begin
        logic [31:0] m, s;
        int k, bad8, bad16, first8, first16, uniq8, uniq16;
        rst4 = 1; rst8 = 1; rst16 = 1;
        seed4 = 4'b0011; seed8 = 8'd1; seed16 = 16'd1;
        // test 1: seed 0011 published sequence
        step();
        check("rst_out", {28'd0, out4}, 32'h3);
        check("rst_done", {31'd0, done4}, 0);
        rst4 = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check($sformatf("seq%0d", i), {28'd0, out4}, {28'd0, seq[i-1]});
            check($sformatf("seq_done%0d", i), {31'd0, done4}, (i == 15) ? 1 : 0);
        end
        // test 2: hold after done while seed wiggles, then reset clears
        for (int i = 0; i < 10; i++) begin
            seed4 = 4'($urandom);
            step();
            check("hold_out", {28'd0, out4}, 32'h3);
            check("hold_done", {31'd0, done4}, 1);
        end
        seed4 = 4'b0101;
        rst4 = 1;
        step();
        check("rerst_out", {28'd0, out4}, 32'h5);
        check("rerst_done", {31'd0, done4}, 0);
        // test 3: zero seed substitutes 1
        seed4 = 0;
        step();
        check("zero_out", {28'd0, out4}, 32'h1);
        rst4 = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            check("zero_done", {31'd0, done4}, (i == 15) ? 1 : 0);
        end
        check("zero_end", {28'd0, out4}, 32'h1);
        // test 4: reset at edge 6 with a new seed
        seed4 = 4'b0011; rst4 = 1;
        step();
        rst4 = 0;
        for (int i = 0; i < 6; i++) step();
        check("mid_out6", {28'd0, out4}, 32'h7);
        seed4 = 4'b1000; rst4 = 1;
        step();
        check("mid_rst_out", {28'd0, out4}, 32'h8);
        check("mid_rst_done", {31'd0, done4}, 0);
        rst4 = 0;
        for (int i = 1; i <= 15; i++) begin
            step();
            if (i == 1) check("mid_first", {28'd0, out4}, 32'h1);
            check("mid_done", {31'd0, done4}, (i == 15) ? 1 : 0);
        end
        check("mid_end", {28'd0, out4}, 32'h8);
        // test 5 / random: random seeds, seed toggling while running, random mid-run resets
        for (int t = 0; t < 20; t++) begin
            seed4 = 4'($urandom);
            s = (seed4 == 0) ? 1 : {28'd0, seed4};
            rst4 = 1;
            step();
            check("rnd_rst", {28'd0, out4}, s);
            rst4 = 0;
            m = s;
            k = $urandom_range(1, 30);
            for (int i = 1; i <= 15; i++) begin
                seed4 = 4'($urandom);
                if (i == k) begin
                    rst4 = 1;
                    step();
                    rst4 = 0;
                    s = (seed4 == 0) ? 1 : {28'd0, seed4};
                    m = s;
                    check("rnd_mid_rst", {28'd0, out4}, s);
                    i = 0;
                    k = 0;
                    continue;
                end
                step();
                m = ref_next(4, m);
                check("rnd_out", {28'd0, out4}, m);
                check("rnd_done", {31'd0, done4}, (i == 15) ? 1 : 0);
            end
        end
        // test 6: full periods for 8 and 16 bits
        step();
        rst8 = 0; rst16 = 0;
        check("n8_rst", {24'd0, out8}, 1);
        check("n16_rst", {16'd0, out16}, 1);
        vis8[1] = 1; vis16[1] = 1;
        bad8 = 0; bad16 = 0; first8 = 0; first16 = 0; uniq8 = 1; uniq16 = 1;
        m = 1; s = 1;
        for (int e = 1; e <= 65535; e++) begin
            seed8 = 8'($urandom); seed16 = 16'($urandom);
            step();
            if (e <= 255) begin
                m = ref_next(8, m);
                if ({24'd0, out8} != m) bad8++;
                if (e < 255) begin
                    if (vis8[out8]) bad8++;
                    else uniq8++;
                    vis8[out8] = 1;
                end
            end
            s = ref_next(16, s);
            if ({16'd0, out16} != s) bad16++;
            if (e < 65535) begin
                if (vis16[out16]) bad16++;
                else uniq16++;
                vis16[out16] = 1;
            end
            if (done8 === 1'b1 && first8 == 0) first8 = e;
            if (done16 === 1'b1 && first16 == 0) first16 = e;
        end
        check("n8_seq", bad8, 0);
        check("n16_seq", bad16, 0);
        check("n8_uniq", uniq8, 255);
        check("n16_uniq", uniq16, 65535);
        check("n8_done_edge", first8, 255);
        check("n16_done_edge", first16, 65535);
        check("n8_end", {24'd0, out8}, 1);
        check("n16_end", {16'd0, out16}, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
